hsadc_stream_arbiter: RTL and testbench
=======================================

Name: hsadc_stream_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one AXI-Stream sink between NUM_CH high-speed ADC channel streams.
- Typical sinks are the USB/FIFO bridge and the hsadc stream interface.
- Each grant is held for exactly PACKET_LEN beats. The final beat is tagged with tlast; every beat carries the source channel ID in tid.
- Sits between the per-channel HSADC AXIS wrappers and the single 16-bit host stream.

Parameters:
- DATA_WIDTH, 16, tdata width of every input and of the output.
- NUM_CH, 2, number of requesting channel streams (2..8).
- PACKET_LEN, 64, beats per grant (>=1).
- ID_WIDTH, $clog2(NUM_CH) (min 1), width of m_tid and of the grant index.
- CNT_WIDTH, 16, width of packet_count.

Ports:
- clk  in  1  stream clock; all logic is synchronous to its rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  permits new grants; does not truncate a packet already in progress.
- s_tdata  in  NUM_CH*DATA_WIDTH  channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tready  out  NUM_CH  per-channel ready.
- m_tdata  out  DATA_WIDTH  output data.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  high on the last beat of a packet.
- m_tid  out  ID_WIDTH  channel that owns the current beat.
- busy  out  1  high while in BURST.
- packet_count  out  CNT_WIDTH  number of completed packets; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, packet_count=0.
  - Outputs: m_tvalid=0, m_tlast=0, s_tready=0, busy=0, m_tid=0, m_tdata=0.
- FSM states: IDLE and BURST.
- IDLE:
  - Outputs: m_tvalid=0, s_tready all 0, busy=0.
  - If enable=1 and |s_tvalid, grant is set to the first i with s_tvalid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_CH. On that edge: state←BURST, beat_cnt←0.
  - Otherwise remain in IDLE.
- BURST, combinational pass-through of the granted channel:
  - m_tdata=s_tdata[grant], m_tvalid=s_tvalid[grant], m_tid=grant, m_tlast=(beat_cnt==PACKET_LEN-1).
  - s_tready[grant]=m_tready; all other s_tready bits are 0.
  - Zero added latency within a packet.
- Handshake:
  - A beat transfers when m_tvalid&&m_tready.
  - Non-last beat: beat_cnt increments.
  - Last beat: state←IDLE, rr_ptr←(grant+1) mod NUM_CH, packet_count←packet_count+1 (wraps at 2^CNT_WIDTH), beat_cnt←0.
- Source stall: if s_tvalid[grant] drops mid-packet, the grant is held indefinitely (no timeout). Other channels are back-pressured.
- Inter-packet gap: exactly one IDLE cycle between a last beat and the next packet's first possible beat. Peak throughput is PACKET_LEN/(PACKET_LEN+1).
- enable:
  - Sampled only in IDLE.
  - Deasserting enable in BURST lets the current packet finish with a full PACKET_LEN beats and tlast, then the block stays in IDLE.
- Simultaneous requests: the round-robin order is strict. A channel that just finished cannot be granted again while any other channel is valid.
- PACKET_LEN=1: every beat has tlast=1; the grant rotates after each beat.
- Reset asserted mid-packet: the packet is aborted with no tlast and all state returns to reset values. The downstream sink is responsible for resynchronising.
- AXIS compliance: the block never deasserts m_tvalid while the granted source holds s_tvalid. Data stability is inherited from compliant sources.

Test Plan:
All scenarios use NUM_CH=2, PACKET_LEN=4, DATA_WIDTH=16.
1. Reset with s_tvalid=2'b11 and rst=0 → m_tvalid=0, s_tready=0, busy=0, packet_count=0. After release, the first m_tvalid appears 1 cycle later with m_tid=0.
2. Ch0 streams 0x0100..0x0103 and ch1 streams 0x0200..0x0203, both always valid, m_tready=1 → output sequence is 0x0100–0x0103 with tlast on 0x0103, one gap cycle, then 0x0200–0x0203 with tid=1 and tlast on 0x0203. packet_count=2.
3. Only ch1 is valid for 3 packets → three consecutive packets with tid=1, each followed by a 1-cycle gap. packet_count=3.
4. m_tready toggled 1,0,1,0 during a packet → m_tdata/m_tvalid held stable while m_tready=0. Exactly 4 beats transfer and tlast appears only on the 4th.
5. enable dropped after beat 1 → beats 2–4 still transfer with tlast. busy falls and no new grant occurs while enable=0 even with s_tvalid=2'b11.
6. rst pulsed low after beat 2 of a ch0 packet → immediate m_tvalid=0 with no tlast. After release, arbitration restarts at ch0 (rr_ptr=0) and packet_count=0.

Source files
------------

// File: rtl/hsadc_stream_arbiter_if.sv
// rtl/hsadc_stream_arbiter_if.sv - stream bundle between HSADC channel wrappers, arbiter and host sink
//
// Purpose: groups the per-channel input streams and the single merged output stream.
// Signals:
//   s_tdata  [NUM_CH*DATA_WIDTH] channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid [NUM_CH]            per-channel valid
//   s_tready [NUM_CH]            per-channel ready
//   m_tdata  [DATA_WIDTH]        merged output data
//   m_tvalid / m_tready          merged output handshake
//   m_tlast                      last beat of a packet
//   m_tid    [ID_WIDTH]          channel owning the current beat
// Modports: master = arbiter side (drives m_* and s_tready), slave = environment side.

interface hsadc_stream_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int ID_WIDTH   = 1
);
  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_CH-1:0]            s_tvalid;
  logic [NUM_CH-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]        m_tdata;
  logic                         m_tvalid;
  logic                         m_tready;
  logic                         m_tlast;
  logic [ID_WIDTH-1:0]          m_tid;

  modport master (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );

  modport slave (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/hsadc_stream_arbiter.sv
// rtl/hsadc_stream_arbiter.sv - packet-granular round-robin arbiter merging HSADC streams
//
// Purpose: shares one stream sink between NUM_CH channel streams. A grant lasts exactly
// PACKET_LEN beats; the final beat carries tlast and every beat carries the channel in tid.
// Ports:
//   clk          stream clock, rising edge
//   rst          asynchronous active-low reset
//   enable       permits new grants (an active packet always completes)
//   bus          stream bundle (master modport): channel inputs and merged output
//   busy         high while a packet grant is held
//   packet_count completed packets, wraps

module hsadc_stream_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int PACKET_LEN = 64,
  parameter int ID_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  hsadc_stream_arbiter_if.master bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] packet_count
);

  localparam int BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] packet_count_q, packet_count_d;

  logic                 pick_found;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 last_beat;
  logic                 xfer;

  // Round-robin search starting at rr_ptr. Walking k downwards lets the
  // smallest offset from rr_ptr overwrite earlier hits, so it wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.s_tvalid[(int'(rr_ptr_q) + k) % NUM_CH]) begin
        pick_found = 1'b1;
        pick_idx   = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_CH);
      end
    end
  end

  assign last_beat = (beat_cnt_q == BEAT_W'(PACKET_LEN - 1));

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    beat_cnt_d     = beat_cnt_q;
    packet_count_d = packet_count_q;
    bus.m_tdata    = '0;
    bus.m_tvalid   = 1'b0;
    bus.m_tlast    = 1'b0;
    bus.m_tid      = '0;
    bus.s_tready   = '0;
    busy           = 1'b0;
    xfer           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && pick_found) begin
          state_d    = S_BURST;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_BURST: begin
        // Zero-latency pass-through of the granted channel; others see ready=0.
        busy         = 1'b1;
        bus.m_tdata  = bus.s_tdata[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        bus.m_tvalid = bus.s_tvalid[grant_q];
        bus.m_tid    = grant_q;
        bus.m_tlast  = last_beat;
        for (int i = 0; i < NUM_CH; i++) begin
          bus.s_tready[i] = (grant_q == ID_WIDTH'(i)) && bus.m_tready;
        end
        xfer = bus.s_tvalid[grant_q] && bus.m_tready;
        if (xfer) begin
          if (last_beat) begin
            state_d        = S_IDLE;
            rr_ptr_d       = ID_WIDTH'((int'(grant_q) + 1) % NUM_CH);
            packet_count_d = packet_count_q + 1'b1;
            beat_cnt_d     = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      rr_ptr_q       <= '0;
      beat_cnt_q     <= '0;
      packet_count_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      rr_ptr_q       <= rr_ptr_d;
      beat_cnt_q     <= beat_cnt_d;
      packet_count_q <= packet_count_d;
    end
  end

  assign packet_count = packet_count_q;

endmodule

// File: tb/tb_hsadc_stream_arbiter.sv
// tb/tb_hsadc_stream_arbiter.sv - self-checking bench for hsadc_stream_arbiter

module tb_hsadc_stream_arbiter;
  localparam int DW = 16;
  localparam int N  = 2;
  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        busy;
  logic [15:0] packet_count;

  hsadc_stream_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(N), .ID_WIDTH(1)) bus ();

  hsadc_stream_arbiter #(
    .DATA_WIDTH(DW), .NUM_CH(N), .PACKET_LEN(PL), .ID_WIDTH(1), .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .bus(bus),
    .busy(busy),
    .packet_count(packet_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the sink (-1 = nobody), beats already sent,
  // next round-robin start, completed packets.
  int owner = -1;
  int beats = 0;
  int ptr   = 0;
  int pkts  = 0;
  logic [15:0] seq [N];

  logic        obs_v, obs_l, obs_id, obs_busy;
  logic [15:0] obs_d;

  function automatic logic [15:0] src(input int ch);
    return 16'((ch + 1) * 256) + seq[ch];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    beats = 0;
    ptr   = 0;
    pkts  = 0;
  endtask

  // Drive one cycle of inputs, compare the DUT to the model mid-cycle, advance the model.
  task automatic step(input logic en, input logic [1:0] v, input logic rdy);
    int pick;
    enable       = en;
    bus.s_tvalid = v;
    bus.m_tready = rdy;
    bus.s_tdata  = {src(1), src(0)};
    @(negedge clk);
    obs_v    = bus.m_tvalid;
    obs_l    = bus.m_tlast;
    obs_id   = bus.m_tid;
    obs_d    = bus.m_tdata;
    obs_busy = busy;
    if (owner < 0) begin
      chk("m_tvalid_idle", 32'(bus.m_tvalid), 0);
      chk("m_tlast_idle", 32'(bus.m_tlast), 0);
      chk("busy_idle", 32'(busy), 0);
      chk("s_tready_idle", 32'(bus.s_tready), 0);
    end else begin
      chk("m_tvalid", 32'(bus.m_tvalid), 32'(v[owner]));
      chk("m_tdata", 32'(bus.m_tdata), 32'(src(owner)));
      chk("m_tid", 32'(bus.m_tid), owner);
      chk("m_tlast", 32'(bus.m_tlast), (beats == PL - 1) ? 1 : 0);
      chk("busy", 32'(busy), 1);
      chk("s_tready", 32'(bus.s_tready), rdy ? (1 << owner) : 0);
    end
    chk("packet_count", 32'(packet_count), pkts % 65536);

    if (owner < 0) begin
      if (en && v != 2'b00) begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && v[(ptr + k) % N]) pick = (ptr + k) % N;
        owner = pick;
        beats = 0;
      end
    end else if (v[owner] && rdy) begin
      seq[owner] = seq[owner] + 16'd1;
      if (beats == PL - 1) begin
        ptr   = (owner + 1) % N;
        owner = -1;
        beats = 0;
        pkts++;
      end else begin
        beats++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int exp_v [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  int exp_d [10] = '{0, 'h100, 'h101, 'h102, 'h103, 0, 'h200, 'h201, 'h202, 'h203};
  int exp_l [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_t [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    seq[0]       = 16'd0;
    seq[1]       = 16'd0;
    rst          = 1'b0;
    enable       = 1'b1;
    bus.s_tvalid = 2'b11;
    bus.m_tready = 1'b1;
    bus.s_tdata  = '0;

    // Reset held with both channels requesting.
    #12;
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 0);
    chk("rst_s_tready", 32'(bus.s_tready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_packet_count", 32'(packet_count), 0);
    chk("rst_m_tdata", 32'(bus.m_tdata), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Both channels always valid: ch0 packet, one gap, ch1 packet.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'b11, 1'b1);
      chk("lit_valid", 32'(obs_v), exp_v[i]);
      if (exp_v[i] != 0) begin
        chk("lit_data", 32'(obs_d), exp_d[i]);
        chk("lit_last", 32'(obs_l), exp_l[i]);
        chk("lit_tid", 32'(obs_id), exp_t[i]);
      end
    end
    chk("lit_count2", 32'(packet_count), 2);

    // Reset after two beats of a ch0 packet.
    step(1'b1, 2'b01, 1'b1);
    step(1'b1, 2'b01, 1'b1);
    step(1'b1, 2'b01, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(bus.m_tvalid), 0);
    chk("midrst_m_tlast", 32'(bus.m_tlast), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_count", 32'(packet_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 2'b11, 1'b1);
    chk("post_rst_idle", 32'(obs_v), 0);
    step(1'b1, 2'b11, 1'b1);
    chk("post_rst_valid", 32'(obs_v), 1);
    chk("post_rst_tid", 32'(obs_id), 0);
    chk("post_rst_data", 32'(obs_d), 'h106);

    // enable dropped after the first beat: packet completes, no new grant.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b11, 1'b1);
      chk("en_drop_valid", 32'(obs_v), 1);
      chk("en_drop_last", 32'(obs_l), (i == 2) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b11, 1'b1);
      chk("en_off_busy", 32'(obs_busy), 0);
      chk("en_off_valid", 32'(obs_v), 0);
    end
    chk("lit_count1", 32'(packet_count), 1);

    // Only ch1 valid: three back-to-back ch1 packets, each followed by a gap.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 2'b10, 1'b1);
      chk("ch1_valid", 32'(obs_v), (i % 5 != 0) ? 1 : 0);
      if (i % 5 != 0) chk("ch1_tid", 32'(obs_id), 1);
    end
    chk("lit_count4", 32'(packet_count), 4);

    // m_tready toggling during packets.
    for (int i = 0; i < 16; i++) step(1'b1, 2'b11, (i % 2) == 0);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0,
           {$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7},
           $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
